// File: rtl/bus_unpack_std_pkg.sv
// bus_unpack_std_pkg
// Shared constants for the 64-bit word to element unpacker.
//   BUS_W        : width of the upstream word bus
//   FRODO_ELEM_W : element width used by the matrix-arithmetic datapath
//   lane_count() : number of ELEM_W lanes in one BUS_W word
package bus_unpack_std_pkg;

    localparam int BUS_W        = 64;
    localparam int FRODO_ELEM_W = 16;

    function automatic int lane_count(input int elem_w);
        return BUS_W / elem_w;
    endfunction

endpackage

// File: rtl/bus_unpack_std_if.sv
// bus_unpack_std_if
// Command, word-input and element-output handshake bundle of the unpacker.
//   cmd_start / cmd_numWords / cmd_canReceive : command request and idle flag
//   i / i_isReady / i_canReceive              : 64-bit word stream in
//   o / o_isReady / o_canReceive / o_isLast   : element stream out
// master drives commands, words and downstream ready; slave is the unpacker.
interface bus_unpack_std_if
    import bus_unpack_std_pkg::*;
#(
    parameter int ELEM_W = FRODO_ELEM_W,
    parameter int CNT_W  = 16
) ();

    logic              cmd_start;
    logic [CNT_W-1:0]  cmd_numWords;
    logic              cmd_canReceive;
    logic [BUS_W-1:0]  i;
    logic              i_isReady;
    logic              i_canReceive;
    logic [ELEM_W-1:0] o;
    logic              o_isReady;
    logic              o_canReceive;
    logic              o_isLast;

    modport master (
        output cmd_start, cmd_numWords, i, i_isReady, o_canReceive,
        input  cmd_canReceive, i_canReceive, o, o_isReady, o_isLast
    );

    modport slave (
        input  cmd_start, cmd_numWords, i, i_isReady, o_canReceive,
        output cmd_canReceive, i_canReceive, o, o_isReady, o_isLast
    );

endinterface

// File: rtl/bus_unpack_std_counter_bus.sv
// counter_bus
// Down-counter of words remaining in the current command.
//   clk, rst  : clock, synchronous active-high reset
//   restart   : load num_steps into the counter
//   num_steps : word count of the new command
//   step      : one word consumed; decrement (saturates at zero)
//   count     : words still to be accepted
module counter_bus #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [CNT_W-1:0] num_steps,
    input  logic             step,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (restart) begin
            count <= num_steps;
        end else if (step && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/bus_unpack_std.sv
// bus_unpack_std
// Splits each 64-bit input word into 64/ELEM_W elements, LSB lane first,
// emitted one per cycle. Runs for a commanded number of words and flags the
// final element of the command.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of bus_unpack_std_if (command, word in, element out)
module bus_unpack_std
    import bus_unpack_std_pkg::*;
#(
    parameter int ELEM_W = FRODO_ELEM_W,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    bus_unpack_std_if.slave bus
);

    localparam int L  = lane_count(ELEM_W);
    localparam int LW = $clog2(L + 1);

    logic             active;
    logic [LW-1:0]    lanes_left;
    logic [BUS_W-1:0] buf_q;
    logic [CNT_W-1:0] words_left;

    logic cmd_take;
    logic cmd_load;
    logic word_xfer;
    logic elem_xfer;
    logic last_lane;

    // Only an idle block takes commands; a zero-word command is consumed
    // without ever raising active.
    assign cmd_take  = bus.cmd_start & ~active;
    assign cmd_load  = cmd_take & (bus.cmd_numWords != '0);

    assign last_lane = (lanes_left == LW'(1));

    // Reload is allowed while the last lane is leaving, so consecutive words
    // stream without a bubble.
    assign bus.i_canReceive   = active & (words_left != '0)
                              & ((lanes_left == '0) | (last_lane & bus.o_canReceive));
    assign word_xfer          = bus.i_isReady & bus.i_canReceive;

    assign bus.o              = buf_q[ELEM_W-1:0];
    assign bus.o_isReady      = (lanes_left != '0) & bus.o_canReceive;
    assign elem_xfer          = bus.o_isReady;
    assign bus.o_isLast       = last_lane & (words_left == '0) & active;
    assign bus.cmd_canReceive = ~active;

    counter_bus #(.CNT_W(CNT_W)) u_counter_bus (
        .clk       (clk),
        .rst       (rst),
        .restart   (cmd_take),
        .num_steps (bus.cmd_numWords),
        .step      (word_xfer),
        .count     (words_left)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q      <= '0;
            lanes_left <= '0;
        end else if (word_xfer) begin
            buf_q      <= bus.i;
            lanes_left <= LW'(L);
        end else if (elem_xfer) begin
            buf_q      <= buf_q >> ELEM_W;
            lanes_left <= lanes_left - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
        end else if (cmd_load) begin
            active <= 1'b1;
        end else if (elem_xfer && bus.o_isLast) begin
            active <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_unpack_std.sv
// tb_bus_unpack_std
// Bench for bus_unpack_std: a 16-bit-element instance driven with scripted and
// random traffic against a queue-based element model, plus an 8-bit build.
module tb_bus_unpack_std;

    logic clk;
    logic rst;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] pre[$];
    int          bp_pat[$];
    int          pat_idx;

    bus_unpack_std_if #(.ELEM_W(16), .CNT_W(16)) u16 ();
    bus_unpack_std_if #(.ELEM_W(8),  .CNT_W(16)) u8 ();

    bus_unpack_std #(.ELEM_W(16), .CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(u16));
    bus_unpack_std #(.ELEM_W(8),  .CNT_W(16)) dut8  (.clk(clk), .rst(rst), .bus(u8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Runs one command on the 16-bit instance. Expected elements come from a
    // queue filled with the lanes of every word the bench hands over; the
    // number of elements sitting in the block decides the expected handshake.
    task automatic run_cmd16(input int n, input int stall_pct, input int offer_pct,
                             input string tag, output int span, output int xfers);
        logic [63:0] words[$];
        logic [15:0] exp_q[$];
        logic [63:0] w;
        int sent, pend, popped, total, first, last, cyc;
        bit ocr, offer, exp_icr, exp_last, oxfer, ixfer;
        sent = 0; pend = 0; popped = 0; total = n * 4;
        first = -1; last = -1; xfers = 0; pat_idx = 0; cyc = 0;
        for (int k = 0; k < n; k++) begin
            if (k < pre.size()) w = pre[k];
            else w = {$urandom, $urandom};
            words.push_back(w);
        end
        pre.delete();

        @(negedge clk);
        u16.cmd_start = 1'b1; u16.cmd_numWords = 16'(n); u16.o_canReceive = 1'b1;
        #1;
        compared++;
        if (u16.cmd_canReceive !== 1'b1) begin
            mismatched++;
            $display("FAIL %s cmd_accept: cmd_canReceive got %b want 1", tag, u16.cmd_canReceive);
        end

        while (popped < total && cyc < 2000) begin
            @(negedge clk);
            u16.cmd_start = 1'b0;
            u16.i_isReady = 1'b0;
            if (bp_pat.size() > 0) begin
                ocr = (pend > 0) ? (bp_pat[pat_idx % bp_pat.size()] != 0) : 1'b1;
                if (pend > 0) pat_idx++;
            end else begin
                ocr = ($urandom_range(99) >= stall_pct);
            end
            offer = ($urandom_range(99) < offer_pct);
            u16.o_canReceive = ocr;
            u16.i = (sent < n) ? words[sent] : {$urandom, $urandom};
            #1;
            exp_icr  = (sent < n) && (pend == 0 || (pend == 1 && ocr));
            exp_last = (pend == 1) && (sent == n);

            compared++;
            if (u16.i_canReceive !== exp_icr) begin
                mismatched++;
                $display("FAIL %s i_canReceive cyc %0d: got %b want %b", tag, cyc, u16.i_canReceive, exp_icr);
            end
            compared++;
            if (u16.o_isReady !== (ocr && pend > 0)) begin
                mismatched++;
                $display("FAIL %s o_isReady cyc %0d: got %b want %b", tag, cyc, u16.o_isReady, (ocr && pend > 0));
            end
            compared++;
            if (u16.o_isLast !== exp_last) begin
                mismatched++;
                $display("FAIL %s o_isLast cyc %0d: got %b want %b", tag, cyc, u16.o_isLast, exp_last);
            end
            compared++;
            if (u16.cmd_canReceive !== 1'b0) begin
                mismatched++;
                $display("FAIL %s busy cmd_canReceive cyc %0d: got %b want 0", tag, cyc, u16.cmd_canReceive);
            end
            if (pend > 0) begin
                compared++;
                if (u16.o !== exp_q[0]) begin
                    mismatched++;
                    $display("FAIL %s o cyc %0d: got %h want %h", tag, cyc, u16.o, exp_q[0]);
                end
            end

            oxfer = ocr && (pend > 0);
            ixfer = offer && exp_icr;
            u16.i_isReady = ixfer;
            if (oxfer) begin
                void'(exp_q.pop_front());
                pend--; popped++; xfers++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (ixfer) begin
                w = words[sent];
                for (int l = 0; l < 4; l++) exp_q.push_back(w[16*l +: 16]);
                pend += 4;
                sent++;
            end
            cyc++;
        end

        @(negedge clk);
        u16.i_isReady = 1'b0; u16.o_canReceive = 1'b1;
        #1;
        compared++;
        if (popped != total) begin
            mismatched++;
            $display("FAIL %s timeout: elements got %0d want %0d", tag, popped, total);
        end
        compared++;
        if (u16.cmd_canReceive !== 1'b1 || u16.o_isReady !== 1'b0 || u16.i_canReceive !== 1'b0) begin
            mismatched++;
            $display("FAIL %s idle_after: ccr/oir/icr got %b%b%b want 100", tag,
                     u16.cmd_canReceive, u16.o_isReady, u16.i_canReceive);
        end
        span = (first < 0) ? 0 : (last - first + 1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        compared++;
        if (u16.cmd_canReceive !== 1'b1 || u16.i_canReceive !== 1'b0 || u16.o_isReady !== 1'b0
            || u16.o_isLast !== 1'b0 || u16.o !== 16'h0) begin
            mismatched++;
            $display("FAIL reset16: ccr/icr/oir/last/o got %b%b%b%b/%h want 1000/0000",
                     u16.cmd_canReceive, u16.i_canReceive, u16.o_isReady, u16.o_isLast, u16.o);
        end
        compared++;
        if (u8.cmd_canReceive !== 1'b1 || u8.i_canReceive !== 1'b0 || u8.o_isReady !== 1'b0
            || u8.o_isLast !== 1'b0 || u8.o !== 8'h0) begin
            mismatched++;
            $display("FAIL reset8: ccr/icr/oir/last/o got %b%b%b%b/%h want 1000/00",
                     u8.cmd_canReceive, u8.i_canReceive, u8.o_isReady, u8.o_isLast, u8.o);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int span, xf;
        pre.push_back(64'h4444_3333_2222_1111);
        pre.push_back(64'h8888_7777_6666_5555);
        run_cmd16(2, 0, 100, "basic", span, xf);
        compared++;
        if (span != 8 || xf != 8) begin
            mismatched++;
            $display("FAIL basic_span: span/xfers got %0d/%0d want 8/8", span, xf);
        end
    endtask

    task automatic test_back_pressure();
        int span, xf;
        bp_pat = '{1, 0, 0, 1, 1, 0, 1, 1};
        run_cmd16(1, 0, 100, "backpressure", span, xf);
        bp_pat.delete();
        compared++;
        if (xf != 4 || span != 7) begin
            mismatched++;
            $display("FAIL backpressure_pulses: xfers/span got %0d/%0d want 4/7", xf, span);
        end
    endtask

    task automatic test_back_to_back();
        int span, xf;
        run_cmd16(3, 0, 100, "zero_bubble", span, xf);
        compared++;
        if (span != 12 || xf != 12) begin
            mismatched++;
            $display("FAIL zero_bubble_span: span/xfers got %0d/%0d want 12/12", span, xf);
        end
    endtask

    task automatic test_random();
        int span, xf, n;
        for (int c = 0; c < 6; c++) begin
            n = $urandom_range(6, 1);
            run_cmd16(n, 30, 60, "random", span, xf);
            compared++;
            if (xf != 4 * n) begin
                mismatched++;
                $display("FAIL random_count: xfers got %0d want %0d", xf, 4 * n);
            end
        end
    endtask

    task automatic test_zero_words();
        @(negedge clk);
        u16.cmd_start = 1'b1; u16.cmd_numWords = 16'd0; u16.o_canReceive = 1'b1;
        u16.i_isReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            u16.cmd_start = 1'b0;
            #1;
            compared++;
            if (u16.i_canReceive !== 1'b0 || u16.o_isReady !== 1'b0 || u16.o_isLast !== 1'b0
                || u16.cmd_canReceive !== 1'b1) begin
                mismatched++;
                $display("FAIL zero_words cyc %0d: icr/oir/last/ccr got %b%b%b%b want 0001", k,
                         u16.i_canReceive, u16.o_isReady, u16.o_isLast, u16.cmd_canReceive);
            end
        end
    endtask

    task automatic test_reset_mid();
        int span, xf;
        @(negedge clk);
        u16.cmd_start = 1'b1; u16.cmd_numWords = 16'd2; u16.o_canReceive = 1'b1;
        @(negedge clk);
        u16.cmd_start = 1'b0; u16.i = 64'hDDDD_CCCC_BBBB_AAAA;
        #1;
        compared++;
        if (u16.i_canReceive !== 1'b1) begin
            mismatched++;
            $display("FAIL rstmid_load: i_canReceive got %b want 1", u16.i_canReceive);
        end
        u16.i_isReady = 1'b1;
        @(negedge clk);
        u16.i_isReady = 1'b0;
        #1;
        compared++;
        if (u16.o !== 16'hAAAA || u16.o_isReady !== 1'b1) begin
            mismatched++;
            $display("FAIL rstmid_e0: o/oir got %h/%b want aaaa/1", u16.o, u16.o_isReady);
        end
        @(negedge clk);
        #1;
        compared++;
        if (u16.o !== 16'hBBBB) begin
            mismatched++;
            $display("FAIL rstmid_e1: o got %h want bbbb", u16.o);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        compared++;
        if (u16.o_isReady !== 1'b0 || u16.i_canReceive !== 1'b0 || u16.cmd_canReceive !== 1'b1) begin
            mismatched++;
            $display("FAIL rstmid_idle: oir/icr/ccr got %b%b%b want 001",
                     u16.o_isReady, u16.i_canReceive, u16.cmd_canReceive);
        end
        rst = 1'b0;
        pre.push_back(64'h0123_4567_89AB_CDEF);
        run_cmd16(1, 0, 100, "after_reset", span, xf);
        compared++;
        if (xf != 4) begin
            mismatched++;
            $display("FAIL after_reset_count: xfers got %0d want 4", xf);
        end
    endtask

    task automatic test_elem8();
        logic [7:0] exp_e;
        @(negedge clk);
        u8.cmd_start = 1'b1; u8.cmd_numWords = 16'd1; u8.o_canReceive = 1'b1;
        @(negedge clk);
        u8.cmd_start = 1'b0; u8.i = 64'h0807_0605_0403_0201;
        #1;
        compared++;
        if (u8.i_canReceive !== 1'b1) begin
            mismatched++;
            $display("FAIL elem8_load: i_canReceive got %b want 1", u8.i_canReceive);
        end
        u8.i_isReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            u8.i_isReady = 1'b0;
            #1;
            exp_e = 8'(k + 1);
            compared++;
            if (u8.o !== exp_e || u8.o_isReady !== 1'b1 || u8.o_isLast !== (k == 7)) begin
                mismatched++;
                $display("FAIL elem8 lane %0d: o/oir/last got %h/%b/%b want %h/1/%b",
                         k, u8.o, u8.o_isReady, u8.o_isLast, exp_e, (k == 7));
            end
        end
        @(negedge clk);
        #1;
        compared++;
        if (u8.cmd_canReceive !== 1'b1 || u8.o_isReady !== 1'b0) begin
            mismatched++;
            $display("FAIL elem8_done: ccr/oir got %b%b want 10", u8.cmd_canReceive, u8.o_isReady);
        end
    endtask

    initial begin
        rst = 1'b1;
        u16.cmd_start = 1'b0; u16.cmd_numWords = '0; u16.i = '0;
        u16.i_isReady = 1'b0; u16.o_canReceive = 1'b1;
        u8.cmd_start = 1'b0; u8.cmd_numWords = '0; u8.i = '0;
        u8.i_isReady = 1'b0; u8.o_canReceive = 1'b1;

        test_reset();
        test_basic();
        test_back_pressure();
        test_back_to_back();
        test_zero_words();
        test_reset_mid();
        test_random();
        test_elem8();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bus_unpack_std.md
Name: bus_unpack_std

Overview:
- Downstream width converter for the 64-bit standard-handshake word stream produced by the serializer path.
- Splits each 64-bit word into 64/ELEM_W elements of ELEM_W bits, LSB lane first, and emits them one per cycle on a standard-handshake element bus.
- Runs under a per-command word count and flags the final element of the command.
- Feeds the matrix-arithmetic datapath, where elements are 16-bit mod-q samples.

Parameters:
- ELEM_W, 16: element width in bits; must divide 64 (legal values 8, 16, 32, 64).
- CNT_W, 16: width of the word counter; must hold the largest cmd_numWords.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset; synchronous, active-high. All state clears on the clk edge where rst=1.
- cmd_start, input, 1: request to start a command. Taken when cmd_canReceive=1.
- cmd_numWords, input, CNT_W: number of 64-bit words in the command. Sampled on cmd accept.
- cmd_canReceive, output, 1: block is idle and can take a command.
- i, input, 64: incoming word.
- i_isReady, input, 1: word transfer strobe. Only legal when i_canReceive=1.
- i_canReceive, output, 1: block accepts a word this cycle.
- o, output, ELEM_W: current element.
- o_isReady, output, 1: element transfer this cycle (valid data AND o_canReceive).
- o_canReceive, input, 1: downstream accepts an element.
- o_isLast, output, 1: the element being presented is the final element of the command.

Behaviour:
- Definitions:
  - L = 64/ELEM_W lanes per word.
  - State: wordsLeft[CNT_W], buf[64], lanesLeft[clog2(L+1)], active.
- Reset state:
  - active=0, wordsLeft=0, lanesLeft=0, buf=0.
  - Outputs after reset: cmd_canReceive=1, i_canReceive=0, o_isReady=0, o_isLast=0, o=0.
- Command accept:
  - cmd_canReceive = ~active.
  - When cmd_start & cmd_canReceive and cmd_numWords≠0: wordsLeft←cmd_numWords, active←1 on the next edge.
  - cmd_numWords=0 is accepted but creates no activity; cmd_canReceive stays 1.
- Word intake:
  - i_canReceive = active & wordsLeft≠0 & (lanesLeft=0 | (lanesLeft=1 & o_canReceive)).
  - This allows a zero-bubble reload in the same cycle the last lane leaves.
  - On i_isReady: buf←i, lanesLeft←L, wordsLeft←wordsLeft-1.
  - An i_isReady asserted while i_canReceive=0 is a protocol violation. The block ignores it and does not change state.
- Element output:
  - o = buf[ELEM_W-1:0].
  - o_isReady = (lanesLeft≠0) & o_canReceive.
  - On an element transfer without a reload: buf←buf>>ELEM_W (zero fill), lanesLeft←lanesLeft-1.
  - When o is not transferring, o is held stable.
- Latency and throughput:
  - A word accepted at edge t gives its first element at o in cycle t+1.
  - With o_canReceive held at 1 and words offered on time, throughput is 1 element per cycle.
  - The pipeline has no bubbles between words.
- Last element:
  - o_isLast = (lanesLeft=1) & (wordsLeft=0) & active.
  - When that element transfers, active←0. cmd_canReceive=1 from the next cycle.
  - A new command cannot be accepted in the same cycle as the last element.
- Back-pressure:
  - o_canReceive=0 freezes buf and lanesLeft.
  - i_canReceive drops to 0 when lanesLeft=1 & o_canReceive=0, and when lanesLeft>1.
- ELEM_W=64: L=1. The block degenerates to a registered pass-through with a word count.
- Reset mid-command: the buffered word and all remaining elements are dropped. The block returns to the idle reset state on the next edge.

Decomposition:
- Shared constants go in the shared config include:
  - BUS_W=64.
  - FRODO element width 16.
  - Lane count L computed as a localparam from ELEM_W.
- One sub-module is natural:
  - The word-count/command logic reuses the existing counter_bus.
  - restart = cmd_start.
  - numSteps = cmd_numWords.
  - isReady = i_isReady.
- Lane tracking stays inline in bus_unpack_std.
- The cmd_canReceive gating on active is implemented locally and is not taken from counter_bus.canRestart.

Test Plan:
1. Basic unpack, no back-pressure.
   - Stimulus: ELEM_W=16, numWords=2, i=64'h4444_3333_2222_1111 then 64'h8888_7777_6666_5555, o_canReceive=1.
   - Required: o sequence 1111,2222,3333,4444,5555,6666,7777,8888 on 8 consecutive cycles. o_isLast=1 only on 8888. cmd_canReceive=1 the following cycle.
2. Back-pressure.
   - Stimulus: o_canReceive pattern 1,0,0,1,1,0,1,1 on a one-word command.
   - Required: o holds stable during the 0 cycles. i_canReceive stays 0 until the 4th element transfers. Exactly 4 o_isReady pulses.
3. Zero-bubble reload.
   - Stimulus: upstream offers words every cycle i_canReceive=1.
   - Required: i_canReceive=1 in the cycle the 4th lane transfers. No idle o cycle between words across a 3-word command (12 elements in 12 cycles).
4. Zero-word command.
   - Stimulus: cmd_start with numWords=0.
   - Required: i_canReceive, o_isReady and o_isLast stay 0. cmd_canReceive stays 1.
5. Reset mid-command.
   - Stimulus: assert rst after 2 of 4 elements of word 1 of a 2-word command.
   - Required: the next cycle shows o_isReady=0, i_canReceive=0, cmd_canReceive=1. A fresh 1-word command then unpacks correctly.
6. ELEM_W=8 build.
   - Stimulus: numWords=1, i=64'h0807_0605_0403_0201.
   - Required: o = 01..08 in 8 cycles. o_isLast only on 08.
